// File: rtl/io_bus_reg_slave.sv
// IO bus register-file slave: decodes an 8-bit address window and answers one 4-phase handshake per access.
// Define BUS_TIMEOUT_EN to add the release timeout (S_ABORT, timeout_err); otherwise timeout_err is tied 0.
module io_bus_reg_slave #(
    parameter logic [7:0]  BASE_ADDR      = 8'h10,
    parameter int          NOS_RW_REGS    = 4,
    parameter int          NOS_RO_REGS    = 4,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bus_RW,
    input  logic                        bus_handshake_1,
    output logic                        bus_handshake_2,
    input  logic [7:0]                  bus_reg_address,
    input  logic [31:0]                 bus_data_out,
    output logic [31:0]                 bus_data_in,
    output logic [NOS_RW_REGS*32-1:0]   ctrl_regs,
    input  logic [NOS_RO_REGS*32-1:0]   status_in,
    output logic                        reg_wr_strobe,
    output logic [7:0]                  reg_wr_index,
    output logic                        ro_write_err,
    output logic                        timeout_err,
    output logic [2:0]                  state_dbg
);

`ifdef BUS_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_DECODE       = 3'd1,
        S_ACK          = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_ABORT        = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_DECODE       = 3'd1,
        S_ACK          = 3'd2,
        S_WAIT_RELEASE = 3'd3
    } state_t;
`endif

    localparam logic [8:0] NOS_REGS   = 9'(NOS_RW_REGS + NOS_RO_REGS);
    localparam logic [8:0] NOS_RW_LIM = 9'(NOS_RW_REGS);

    // The release counter is 16 bits wide, so the timeout must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("io_bus_reg_slave: TIMEOUT_CYCLES out of range");
    end

    state_t      state_q, state_d;
    logic        hs2_q, hs2_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] ctrl_q [NOS_RW_REGS];
    logic [31:0] ctrl_d [NOS_RW_REGS];
    logic        strobe_q, strobe_d;
    logic [7:0]  index_q, index_d;
    logic        ro_err_q, ro_err_d;
    logic [7:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_rw_q, wr_rw_d;
    logic        wr_ro_q, wr_ro_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
`endif

    logic [7:0]  off;
    logic        hit;
    logic        off_is_rw;
    logic [31:0] rd_val;

    // Offset wraps mod 256; the explicit >= check keeps addresses below the window out.
    assign off       = bus_reg_address - BASE_ADDR;
    assign hit       = (bus_reg_address >= BASE_ADDR) && ({1'b0, off} < NOS_REGS);
    assign off_is_rw = {1'b0, off} < NOS_RW_LIM;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NOS_RW_REGS; i++) begin
            if (off == 8'(i)) rd_val = ctrl_q[i];
        end
        for (int j = 0; j < NOS_RO_REGS; j++) begin
            if (off == 8'(NOS_RW_REGS + j)) rd_val = status_in[32*j +: 32];
        end
    end

    always_comb begin
        state_d  = state_q;
        hs2_d    = hs2_q;
        dout_d   = dout_q;
        ctrl_d   = ctrl_q;
        strobe_d = 1'b0;
        index_d  = index_q;
        ro_err_d = 1'b0;
        off_d    = off_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_rw_d  = wr_rw_q;
        wr_ro_d  = wr_ro_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_handshake_1 && hit) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Bus fields are captured here; later changes from the master are ignored.
                if (hit) begin
                    off_d   = off;
                    wdata_d = bus_data_out;
                    wr_rw_d = !bus_RW && off_is_rw;
                    wr_ro_d = !bus_RW && !off_is_rw;
                    rd_d    = bus_RW ? rd_val : 32'h0;
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                // Register update and strobe land on the same edge as the acknowledge.
                hs2_d  = 1'b1;
                dout_d = rd_q;
                if (wr_rw_q) begin
                    for (int i = 0; i < NOS_RW_REGS; i++) begin
                        if (off_q == 8'(i)) ctrl_d[i] = wdata_q;
                    end
                    strobe_d = 1'b1;
                    index_d  = off_q;
                end
                ro_err_d = wr_ro_q;
`ifdef BUS_TIMEOUT_EN
                cnt_d    = 16'h0;
`endif
                state_d  = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (!bus_handshake_1) begin
                    hs2_d   = 1'b0;
                    dout_d  = 32'h0;
                    state_d = S_IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    hs2_d   = 1'b0;
                    dout_d  = 32'h0;
                    tmo_d   = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
`ifdef BUS_TIMEOUT_EN
            S_ABORT: begin
                // A stuck request must be released before another access is accepted.
                if (!bus_handshake_1) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            hs2_q    <= 1'b0;
            dout_q   <= 32'h0;
            for (int i = 0; i < NOS_RW_REGS; i++) ctrl_q[i] <= RESET_VALUE;
            strobe_q <= 1'b0;
            index_q  <= 8'h0;
            ro_err_q <= 1'b0;
            off_q    <= 8'h0;
            wdata_q  <= 32'h0;
            rd_q     <= 32'h0;
            wr_rw_q  <= 1'b0;
            wr_ro_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= 16'h0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hs2_q    <= hs2_d;
            dout_q   <= dout_d;
            ctrl_q   <= ctrl_d;
            strobe_q <= strobe_d;
            index_q  <= index_d;
            ro_err_q <= ro_err_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_rw_q  <= wr_rw_d;
            wr_ro_q  <= wr_ro_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    for (genvar g = 0; g < NOS_RW_REGS; g++) begin : g_ctrl
        assign ctrl_regs[32*g +: 32] = ctrl_q[g];
    end

    assign bus_handshake_2 = hs2_q;
    assign bus_data_in     = dout_q;
    assign reg_wr_strobe   = strobe_q;
    assign reg_wr_index    = index_q;
    assign ro_write_err    = ro_err_q;
    assign state_dbg       = state_q;
`ifdef BUS_TIMEOUT_EN
    assign timeout_err     = tmo_q;
`else
    assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_reg_slave.sv
// Testbench for io_bus_reg_slave: vector table, randomised accesses against a register model,
// reset during a handshake, and a long-held request (timeout behaviour follows BUS_TIMEOUT_EN).
module tb_io_bus_reg_slave;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bus_RW = 1'b0;
    logic         bus_handshake_1 = 1'b0;
    logic         bus_handshake_2;
    logic [7:0]   bus_reg_address = 8'h0;
    logic [31:0]  bus_data_out = 32'h0;
    logic [31:0]  bus_data_in;
    logic [127:0] ctrl_regs;
    logic [127:0] status_in;
    logic         reg_wr_strobe;
    logic [7:0]   reg_wr_index;
    logic         ro_write_err;
    logic         timeout_err;
    logic [2:0]   state_dbg;

    always #5 clk = ~clk;

    io_bus_reg_slave dut (
        .clk             (clk),
        .reset           (reset),
        .bus_RW          (bus_RW),
        .bus_handshake_1 (bus_handshake_1),
        .bus_handshake_2 (bus_handshake_2),
        .bus_reg_address (bus_reg_address),
        .bus_data_out    (bus_data_out),
        .bus_data_in     (bus_data_in),
        .ctrl_regs       (ctrl_regs),
        .status_in       (status_in),
        .reg_wr_strobe   (reg_wr_strobe),
        .reg_wr_index    (reg_wr_index),
        .ro_write_err    (ro_write_err),
        .timeout_err     (timeout_err),
        .state_dbg       (state_dbg)
    );

    typedef struct {
        logic         rw;
        logic [7:0]   addr;
        logic [31:0]  wdata;
        logic         exp_ack;
        logic [31:0]  exp_rd;
        int           exp_strobes;
        logic [7:0]   exp_idx;
        int           exp_roerr;
        logic [127:0] exp_ctrl;
    } vec_t;

    localparam logic [127:0] C1 = {32'h0, 32'h0, 32'h12345678, 32'h0};
    localparam logic [127:0] C2 = {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF};
    localparam logic [127:0] C3 = {32'h0000A5A5, 32'h0, 32'h12345678, 32'hDEADBEEF};

    logic [31:0] exp_q[$];
    logic [31:0] st  [4];
    logic [31:0] mdl [4];
    vec_t        vt  [16];
    int          n_chk = 0;
    int          n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_vec(input logic rw, input logic [7:0] addr, input logic [31:0] wd);
        vec_t       v;
        logic [7:0] off;
        off           = addr - 8'h10;
        v.rw          = rw;
        v.addr        = addr;
        v.wdata       = wd;
        v.exp_ack     = (addr >= 8'h10) && (off < 8'd8);
        v.exp_rd      = 32'h0;
        v.exp_strobes = 0;
        v.exp_idx     = 8'h0;
        v.exp_roerr   = 0;
        if (v.exp_ack) begin
            if (rw) begin
                v.exp_rd = (off < 8'd4) ? mdl[off[1:0]] : st[off[1:0]];
            end else if (off < 8'd4) begin
                mdl[off[1:0]] = wd;
                v.exp_strobes = 1;
                v.exp_idx     = off;
            end else begin
                v.exp_roerr = 1;
            end
        end
        v.exp_ctrl = {mdl[3], mdl[2], mdl[1], mdl[0]};
        return v;
    endfunction

    // One complete access; called just after a rising edge with handshake_1 low.
    task automatic run_vec(input vec_t v, input string name);
        logic        acked;
        logic        seen_nz;
        logic        unstable;
        int          lat;
        int          strobes;
        int          roerrs;
        int          budget;
        logic [7:0]  idx;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        bus_RW          = v.rw;
        bus_reg_address = v.addr;
        bus_data_out    = v.wdata;
        bus_handshake_1 = 1'b1;
        if (v.exp_ack) exp_q.push_back(v.exp_rd);
        acked = 1'b0; seen_nz = 1'b0; unstable = 1'b0;
        lat = 0; strobes = 0; roerrs = 0; idx = 8'h0; rd = 32'h0;
        budget = v.exp_ack ? 10 : 20;
        for (int c = 1; c <= budget && !acked; c++) begin
            @(posedge clk); #1;
            if (reg_wr_strobe) begin strobes++; idx = reg_wr_index; end
            if (ro_write_err) roerrs++;
            if (bus_data_in != 32'h0) seen_nz = 1'b1;
            if (bus_handshake_2) begin acked = 1'b1; lat = c; rd = bus_data_in; end
        end
        check({name, "_ack"}, 128'(acked), 128'(v.exp_ack));
        if (acked) begin
            check({name, "_latency"}, 128'(lat), 128'(3));
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_ack"}, 128'(1), 128'(0));
            end else begin
                exp_rd = exp_q.pop_front();
                check({name, "_rdata"}, 128'(rd), 128'(exp_rd));
            end
            check({name, "_ctrl"}, ctrl_regs, v.exp_ctrl);
            for (int h = 0; h < 3; h++) begin
                bus_reg_address = 8'($urandom_range(0, 255));
                bus_data_out    = $urandom;
                bus_RW          = ~bus_RW;
                @(posedge clk); #1;
                if (reg_wr_strobe) strobes++;
                if (ro_write_err) roerrs++;
                if (!bus_handshake_2 || bus_data_in != rd) unstable = 1'b1;
            end
            check({name, "_hold_stable"}, 128'(unstable), 128'(0));
            bus_handshake_1 = 1'b0;
            @(posedge clk); #1;
            check({name, "_release_hs2"}, 128'(bus_handshake_2), 128'(0));
            check({name, "_release_data"}, 128'(bus_data_in), 128'(0));
        end else begin
            check({name, "_idle_data"}, 128'(seen_nz), 128'(0));
            bus_handshake_1 = 1'b0;
        end
        @(posedge clk); #1;
        if (reg_wr_strobe) strobes++;
        if (ro_write_err) roerrs++;
        check({name, "_strobes"}, 128'(strobes), 128'(v.exp_strobes));
        if (v.exp_strobes == 1) check({name, "_index"}, 128'(idx), 128'(v.exp_idx));
        check({name, "_roerr"}, 128'(roerrs), 128'(v.exp_roerr));
        check({name, "_ctrl_after"}, ctrl_regs, v.exp_ctrl);
    endtask

    initial begin
        int          rises;
        int          tmos;
        int          fall_c;
        logic        prev;
        logic [31:0] exp_rd;
        vec_t        v;

        st[0] = 32'hA5A50000; st[1] = 32'hCAFEF00D; st[2] = 32'h0BADBEEF; st[3] = 32'h13579BDF;
        status_in = {st[3], st[2], st[1], st[0]};
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

        vt[0]  = '{1'b0, 8'h11, 32'h12345678, 1'b1, 32'h0,         1, 8'h01, 0, C1};
        vt[1]  = '{1'b1, 8'h15, 32'h0,        1'b1, 32'hCAFEF00D,  0, 8'h00, 0, C1};
        vt[2]  = '{1'b0, 8'h30, 32'hAAAAAAAA, 1'b0, 32'h0,         0, 8'h00, 0, C1};
        vt[3]  = '{1'b1, 8'h0F, 32'h0,        1'b0, 32'h0,         0, 8'h00, 0, C1};
        vt[4]  = '{1'b0, 8'h14, 32'hFFFFFFFF, 1'b1, 32'h0,         0, 8'h00, 1, C1};
        vt[5]  = '{1'b1, 8'h11, 32'h0,        1'b1, 32'h12345678,  0, 8'h00, 0, C1};
        vt[6]  = '{1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 32'h0,         1, 8'h00, 0, C2};
        vt[7]  = '{1'b0, 8'h13, 32'h0000A5A5, 1'b1, 32'h0,         1, 8'h03, 0, C3};
        vt[8]  = '{1'b1, 8'h17, 32'h0,        1'b1, 32'h13579BDF,  0, 8'h00, 0, C3};
        vt[9]  = '{1'b1, 8'h18, 32'h0,        1'b0, 32'h0,         0, 8'h00, 0, C3};
        vt[10] = '{1'b1, 8'hFF, 32'h0,        1'b0, 32'h0,         0, 8'h00, 0, C3};
        vt[11] = '{1'b1, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF,  0, 8'h00, 0, C3};
        vt[12] = '{1'b1, 8'h12, 32'h0,        1'b1, 32'h0,         0, 8'h00, 0, C3};
        vt[13] = '{1'b0, 8'h17, 32'h01010101, 1'b1, 32'h0,         0, 8'h00, 1, C3};
        vt[14] = '{1'b1, 8'h13, 32'h0,        1'b1, 32'h0000A5A5,  0, 8'h00, 0, C3};
        vt[15] = '{1'b1, 8'h14, 32'h0,        1'b1, 32'hA5A50000,  0, 8'h00, 0, C3};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_hs2", 128'(bus_handshake_2), 128'(0));
        check("reset_data", 128'(bus_data_in), 128'(0));
        check("reset_ctrl", ctrl_regs, 128'(0));
        check("reset_strobe", 128'(reg_wr_strobe), 128'(0));
        check("reset_index", 128'(reg_wr_index), 128'(0));
        check("reset_roerr", 128'(ro_write_err), 128'(0));
        check("reset_tmo", 128'(timeout_err), 128'(0));
        check("reset_state", 128'(state_dbg), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        mdl[0] = 32'hDEADBEEF; mdl[1] = 32'h12345678; mdl[2] = 32'h0; mdl[3] = 32'h0000A5A5;
        for (int i = 0; i < 24; i++) begin
            v = mk_vec(1'($urandom_range(0, 1)), 8'($urandom_range(8'h0E, 8'h19)), $urandom);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for release after a write to offset 0
        bus_RW = 1'b0; bus_reg_address = 8'h10; bus_data_out = 32'h55AA55AA; bus_handshake_1 = 1'b1;
        exp_q.push_back(32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_ack", 128'(bus_handshake_2), 128'(1));
        check("rst_mid_ctrl0", 128'(ctrl_regs[31:0]), 128'(32'h55AA55AA));
        if (exp_q.size() != 0) exp_rd = exp_q.pop_front();
        check("rst_mid_rdata", 128'(bus_data_in), 128'(exp_rd));
        reset = 1'b0; bus_handshake_1 = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_hs2", 128'(bus_handshake_2), 128'(0));
        check("rst_mid_ctrl_clr", ctrl_regs, 128'(0));
        check("rst_mid_state", 128'(state_dbg), 128'(0));
        reset = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        @(posedge clk); #1;
        run_vec(mk_vec(1'b0, 8'h12, 32'h0F0F0F0F), "post_rst_wr");
        run_vec(mk_vec(1'b1, 8'h12, 32'h0), "post_rst_rd");

        // Request held for 1500 cycles
        bus_RW = 1'b1; bus_reg_address = 8'h16; bus_data_out = 32'h0; bus_handshake_1 = 1'b1;
        exp_q.push_back(st[2]);
        rises = 0; tmos = 0; fall_c = 0; prev = 1'b0;
        for (int c = 1; c <= 1500; c++) begin
            @(posedge clk); #1;
            if (bus_handshake_2 && !prev) begin
                rises++;
                if (exp_q.size() != 0) begin
                    exp_rd = exp_q.pop_front();
                    check("stuck_rdata", 128'(bus_data_in), 128'(exp_rd));
                end
            end
            if (!bus_handshake_2 && prev) fall_c = c;
            if (timeout_err) tmos++;
            prev = bus_handshake_2;
        end
        check("stuck_acks", 128'(rises), 128'(1));
`ifdef BUS_TIMEOUT_EN
        check("stuck_tmo_pulses", 128'(tmos), 128'(1));
        check("stuck_drop_window", 128'(fall_c >= 995 && fall_c <= 1010), 128'(1));
        check("stuck_abort_data", 128'(bus_data_in), 128'(0));
`else
        check("stuck_tmo_pulses", 128'(tmos), 128'(0));
        check("stuck_no_drop", 128'(fall_c), 128'(0));
        check("stuck_still_ack", 128'(bus_handshake_2), 128'(1));
`endif
        bus_handshake_1 = 1'b0;
        @(posedge clk); #1;
        check("stuck_release_hs2", 128'(bus_handshake_2), 128'(0));
        check("stuck_release_data", 128'(bus_data_in), 128'(0));
        @(posedge clk); #1;
        run_vec(mk_vec(1'b1, 8'h16, 32'h0), "after_stuck_rd");

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
